// File: rtl/ecc_op_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_ctrl_pkg
// Description : Shared definitions for the ECC operation sequencer:
//               operation codes, codeword-width codes, the FSM state
//               encoding and the width-to-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_ctrl_pkg;

  // Operation select, taken from CTRL[1:0]
  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // Codeword width select, taken from CODEWORD_WIDTH[1:0]
  localparam logic [1:0] W8      = 2'b00;
  localparam logic [1:0] W16     = 2'b01;
  localparam logic [1:0] W32     = 2'b10;
  localparam logic [1:0] W_ILL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ENC  = 3'd1,
    S_DEC  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Mask of the active codeword bits; the illegal code yields an empty mask
  // (the operation is rejected before the mask is ever applied).
  function automatic logic [31:0] width_mask(input logic [1:0] width);
    case (width)
      W8:      width_mask = 32'h0000_00FF;
      W16:     width_mask = 32'h0000_FFFF;
      W32:     width_mask = 32'hFFFF_FFFF;
      default: width_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_op_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : ecc_op_watchdog
// Description : Per-phase cycle counter for the ECC sequencer. Cleared
//               while the sequencer is outside a datapath phase or when a
//               phase completes; counts while enabled and flags expiry when
//               the count reaches TIMEOUT_CYC-1. Only instantiated when
//               ECC_OP_CTRL_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// Ports       : clk, rst (async, active-low)
//               clear   - force count to zero
//               enable  - count this cycle (phase active)
//               expired - count has reached the limit while enabled
// ============================================================================
module ecc_op_watchdog
  import ecc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/ecc_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ecc_op_ctrl
// Description : Operation sequencer for the ECC encoder/decoder datapath.
//               On a CTRL write it runs one encode, decode or full-channel
//               (encode, add noise, decode) operation through the encoder
//               and decoder using a start/done handshake, and returns the
//               result, the error count and status.
// Revision    : 1.0 - initial release
// Options     : ECC_OP_CTRL_TIMEOUT_EN - per-phase watchdog; a phase that
//               does not complete within TIMEOUT_CYC cycles ends in ERR with
//               num_of_errors = 3.
// Ports       : clk, rst (async, active-low)
//               start, ctrl, data_in, codeword_width, noise - register bank
//               enc_start/enc_din/enc_done/enc_dout         - encoder
//               dec_start/dec_din/dec_done/dec_dout/dec_err - decoder
//               busy, data_out, data_out_valid, num_of_errors, op_err
// ============================================================================
module ecc_op_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int AMBA_WORD   = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AMBA_WORD-1:0] ctrl,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic [AMBA_WORD-1:0] codeword_width,
  input  logic [AMBA_WORD-1:0] noise,
  output logic                 enc_start,
  output logic [AMBA_WORD-1:0] enc_din,
  input  logic                 enc_done,
  input  logic [AMBA_WORD-1:0] enc_dout,
  output logic                 dec_start,
  output logic [AMBA_WORD-1:0] dec_din,
  input  logic                 dec_done,
  input  logic [AMBA_WORD-1:0] dec_dout,
  input  logic [1:0]           dec_err,
  output logic                 busy,
  output logic [AMBA_WORD-1:0] data_out,
  output logic                 data_out_valid,
  output logic [1:0]           num_of_errors,
  output logic                 op_err
);

  state_t               state;
  logic [1:0]           op_q;
  logic [AMBA_WORD-1:0] mask_q;
  logic [AMBA_WORD-1:0] noise_q;
  logic [AMBA_WORD-1:0] mask_in;
  logic                 enc_ack;
  logic                 dec_ack;

  assign mask_in = AMBA_WORD'(width_mask(codeword_width[1:0]));

  // A done pulse is honoured only after the start pulse: the cycle in which
  // the (registered) start is still high is the phase entry cycle.
  assign enc_ack = (state == S_ENC) && enc_done && !enc_start;
  assign dec_ack = (state == S_DEC) && dec_done && !dec_start;

  logic unused_bits;
  assign unused_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};

`ifdef ECC_OP_CTRL_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // Restart the count on every phase entry, including ENC -> DEC.
  assign wd_enable = (state == S_ENC) || (state == S_DEC);
  assign wd_clear  = !wd_enable || enc_ack;

  ecc_op_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      op_q           <= '0;
      mask_q         <= '0;
      noise_q        <= '0;
      enc_start      <= 1'b0;
      enc_din        <= '0;
      dec_start      <= 1'b0;
      dec_din        <= '0;
      busy           <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      num_of_errors  <= 2'd0;
      op_err         <= 1'b0;
    end else begin
      enc_start      <= 1'b0;
      dec_start      <= 1'b0;
      data_out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= ctrl[1:0];
            mask_q  <= mask_in;
            noise_q <= noise & mask_in;
            busy    <= 1'b1;
            op_err  <= 1'b0;
            if ((ctrl[1:0] == OP_ILL) || (codeword_width[1:0] == W_ILL)) begin
              op_err <= 1'b1;
              state  <= S_ERR;
            end else if (ctrl[1:0] == OP_DEC) begin
              dec_din   <= data_in & mask_in;
              dec_start <= 1'b1;
              state     <= S_DEC;
            end else begin
              enc_din   <= data_in & mask_in;
              enc_start <= 1'b1;
              state     <= S_ENC;
            end
          end
        end

        S_ENC: begin
          if (enc_ack) begin
            if (op_q == OP_FULL) begin
              // Channel model: the noise pattern flips bits of the codeword.
              dec_din   <= enc_dout ^ noise_q;
              dec_start <= 1'b1;
              state     <= S_DEC;
            end else begin
              data_out       <= enc_dout & mask_q;
              num_of_errors  <= 2'd0;
              data_out_valid <= 1'b1;
              state          <= S_DONE;
            end
          end
`ifdef ECC_OP_CTRL_TIMEOUT_EN
          else if (wd_expired) begin
            op_err        <= 1'b1;
            num_of_errors <= 2'b11;
            state         <= S_ERR;
          end
`endif
        end

        S_DEC: begin
          if (dec_ack) begin
            data_out       <= dec_dout & mask_q;
            num_of_errors  <= dec_err;
            data_out_valid <= 1'b1;
            state          <= S_DONE;
          end
`ifdef ECC_OP_CTRL_TIMEOUT_EN
          else if (wd_expired) begin
            op_err        <= 1'b1;
            num_of_errors <= 2'b11;
            state         <= S_ERR;
          end
`endif
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_ERR: begin
          op_err <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecc_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_op_ctrl
// Description : Self-checking bench for ecc_op_ctrl. Directed operations
//               push their expected result (data, error count, cycle of the
//               valid pulse) into a scoreboard queue; a monitor pops and
//               compares on every data_out_valid pulse. Point checks on the
//               encoder/decoder handshake and status flags are made by the
//               stimulus. The timeout case runs only with
//               ECC_OP_CTRL_TIMEOUT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_op_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] ctrl;
  logic [31:0] data_in;
  logic [31:0] codeword_width;
  logic [31:0] noise;
  logic        enc_start;
  logic [31:0] enc_din;
  logic        enc_done;
  logic [31:0] enc_dout;
  logic        dec_start;
  logic [31:0] dec_din;
  logic        dec_done;
  logic [31:0] dec_dout;
  logic [1:0]  dec_err;
  logic        busy;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [1:0]  num_of_errors;
  logic        op_err;

  ecc_op_ctrl #(
    .AMBA_WORD   (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ctrl           (ctrl),
    .data_in        (data_in),
    .codeword_width (codeword_width),
    .noise          (noise),
    .enc_start      (enc_start),
    .enc_din        (enc_din),
    .enc_done       (enc_done),
    .enc_dout       (enc_dout),
    .dec_start      (dec_start),
    .dec_din        (dec_din),
    .dec_done       (dec_done),
    .dec_dout       (dec_dout),
    .dec_err        (dec_err),
    .busy           (busy),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .num_of_errors  (num_of_errors),
    .op_err         (op_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  nerr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          enc_cnt = 0;
  int          dec_cnt = 0;
  int          valid_cnt = 0;

  // Behavioural encoder/decoder: answer one cycle after the start pulse.
  logic        enc_auto = 1'b1;
  logic        dec_auto = 1'b1;
  int          dec_lat  = 1;
  logic [31:0] enc_resp = '0;
  logic [31:0] dec_resp = '0;
  logic [1:0]  dec_err_resp = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (enc_start) enc_cnt++;
    if (dec_start) dec_cnt++;
    if (data_out_valid) begin
      exp_t e;
      valid_cnt++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got data_out=0x%0h, expected no valid pulse (cycle %0d)",
                 data_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_data_out",      data_out,             e.data);
        chk("sb_num_of_errors", 32'(num_of_errors),   32'(e.nerr));
        chk("sb_valid_cycle",   32'(cyc),             32'(e.cyc));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (enc_start && enc_auto) begin
      @(posedge clk); #1;
      enc_done = 1'b1;
      enc_dout = enc_resp;
      @(posedge clk); #1;
      enc_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (dec_start && dec_auto) begin
      repeat (dec_lat) @(posedge clk);
      #1;
      dec_done = 1'b1;
      dec_dout = dec_resp;
      dec_err  = dec_err_resp;
      @(posedge clk); #1;
      dec_done = 1'b0;
    end
  end

  // Called 1 time unit after a rising edge; leaves start asserted for exactly
  // that cycle and returns 1 time unit into the next one.
  task automatic do_start(input logic [31:0] c, input logic [31:0] w,
                          input logic [31:0] d, input logic [31:0] n, output int c0);
    ctrl           = c;
    codeword_width = w;
    data_in        = d;
    noise          = n;
    start          = 1'b1;
    c0             = cyc;
    @(posedge clk); #1;
    start          = 1'b0;
  endtask

  // Advance to the falling edge inside cycle c (c must not be in the past).
  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    int e0;
    int d0;
    int v0;

    rst = 1'b1; start = 1'b0; ctrl = '0; data_in = '0; codeword_width = '0; noise = '0;
    enc_done = 1'b0; enc_dout = '0; dec_done = 1'b0; dec_dout = '0; dec_err = '0;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("rst_busy",     32'(busy),           32'd0);
    chk("rst_data_out", data_out,            32'd0);
    chk("rst_nerr",     32'(num_of_errors),  32'd0);
    chk("rst_op_err",   32'(op_err),         32'd0);
    chk("rst_valid",    32'(data_out_valid), 32'd0);
    chk("rst_starts",   32'({enc_start, dec_start}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    resync();

    // 1. Encode, 8-bit
    enc_resp = 32'h1234;
    e0 = enc_cnt;
    do_start(32'd0, 32'd0, 32'h1A5, 32'd0, c0);
    sb.push_back('{32'h34, 2'd0, c0 + 3});
    at_cycle(c0 + 1);
    chk("enc_start_c1", 32'(enc_start), 32'd1);
    chk("enc_din",      enc_din,        32'hA5);
    chk("enc_busy",     32'(busy),      32'd1);
    at_cycle(c0 + 4);
    chk("enc_busy_end", 32'(busy),      32'd0);
    chk("enc_one_start", 32'(enc_cnt - e0), 32'd1);
    resync();

    // 2. Full channel, 16-bit
    enc_resp = 32'hBEEF; dec_resp = 32'h00C3; dec_err_resp = 2'd1;
    do_start(32'd2, 32'd1, 32'h5A5A, 32'h10004, c0);
    sb.push_back('{32'hC3, 2'd1, c0 + 5});
    at_cycle(c0 + 1);
    chk("full_enc_din", enc_din, 32'h5A5A);
    at_cycle(c0 + 3);
    chk("full_dec_start", 32'(dec_start), 32'd1);
    chk("full_dec_din",   dec_din,        32'hBEEB);
    at_cycle(c0 + 6);
    chk("full_busy_end", 32'(busy), 32'd0);
    resync();

    // 3a. Illegal op
    e0 = enc_cnt; d0 = dec_cnt;
    do_start(32'd3, 32'd0, 32'h77, 32'd0, c0);
    at_cycle(c0 + 1);
    chk("illop_busy",   32'(busy),   32'd1);
    chk("illop_op_err", 32'(op_err), 32'd1);
    at_cycle(c0 + 2);
    chk("illop_busy_end",  32'(busy),   32'd0);
    chk("illop_op_err_st", 32'(op_err), 32'd1);
    chk("illop_no_start",  32'((enc_cnt - e0) + (dec_cnt - d0)), 32'd0);
    chk("illop_data_hold", data_out, 32'hC3);
    resync();

    // 3b. Legal start clears op_err (32-bit encode)
    enc_resp = 32'hABCD_0123;
    do_start(32'd0, 32'd2, 32'hDEAD_BEEF, 32'd0, c0);
    sb.push_back('{32'hABCD_0123, 2'd0, c0 + 3});
    at_cycle(c0 + 1);
    chk("clr_op_err",  32'(op_err), 32'd0);
    chk("enc32_din",   enc_din,     32'hDEAD_BEEF);
    at_cycle(c0 + 4);
    resync();

    // 3c. Illegal width
    e0 = enc_cnt;
    do_start(32'd0, 32'd3, 32'h11, 32'd0, c0);
    at_cycle(c0 + 1);
    chk("illw_op_err", 32'(op_err), 32'd1);
    at_cycle(c0 + 2);
    chk("illw_no_start", 32'(enc_cnt - e0), 32'd0);
    resync();

    // 4. Starts while busy are ignored
    dec_lat = 4; dec_resp = 32'h39E; dec_err_resp = 2'd2;
    d0 = dec_cnt;
    do_start(32'd1, 32'd0, 32'h1055, 32'd0, c0);
    sb.push_back('{32'h9E, 2'd2, c0 + 6});
    do_start(32'd0, 32'd2, 32'hFF, 32'd0, e0);
    do_start(32'd2, 32'd1, 32'hFF, 32'd0, e0);
    do_start(32'd1, 32'd0, 32'hFF, 32'd0, e0);
    at_cycle(c0 + 4);
    chk("busy_dec_din", dec_din,    32'h55);
    chk("busy_busy",    32'(busy),  32'd1);
    at_cycle(c0 + 8);
    chk("busy_one_dec_start", 32'(dec_cnt - d0), 32'd1);
    dec_lat = 1;
    resync();

    // 7. Done coincident with the start pulse is ignored
    dec_auto = 1'b0;
    do_start(32'd1, 32'd1, 32'h12345, 32'd0, c0);
    sb.push_back('{32'hBCD1, 2'd1, c0 + 4});
    dec_done = 1'b1; dec_dout = 32'h1111; dec_err = 2'd0;
    at_cycle(c0 + 1);
    chk("early_dec_din", dec_din, 32'h2345);
    resync();
    dec_done = 1'b0;
    at_cycle(c0 + 2);
    chk("early_still_busy", 32'(busy), 32'd1);
    resync();
    dec_done = 1'b1; dec_dout = 32'h2BCD1; dec_err = 2'd1;
    resync();
    dec_done = 1'b0;
    at_cycle(c0 + 5);
    resync();

    // 5. Reset mid-DEC; late done ignored
    do_start(32'd1, 32'd0, 32'h3C, 32'd0, c0);
    at_cycle(c0 + 2);
    chk("mid_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy",     32'(busy),          32'd0);
    chk("mid_rst_data_out", data_out,           32'd0);
    chk("mid_rst_nerr",     32'(num_of_errors), 32'd0);
    resync();
    rst = 1'b1;
    v0 = valid_cnt;
    resync();
    dec_done = 1'b1; dec_dout = 32'hFF; dec_err = 2'd1;
    resync();
    dec_done = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("late_done_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("late_done_busy",     32'(busy),           32'd0);
    chk("late_done_data",     data_out,            32'd0);
    dec_auto = 1'b1;
    resync();

`ifdef ECC_OP_CTRL_TIMEOUT_EN
    // 6. Encoder never answers
    enc_auto = 1'b0;
    do_start(32'd0, 32'd0, 32'h11, 32'd0, c0);
    at_cycle(c0 + 8);
    chk("to_op_err_before", 32'(op_err), 32'd0);
    chk("to_busy_before",   32'(busy),   32'd1);
    at_cycle(c0 + 9);
    chk("to_op_err", 32'(op_err),        32'd1);
    chk("to_nerr",   32'(num_of_errors), 32'd3);
    at_cycle(c0 + 11);
    chk("to_busy_end", 32'(busy), 32'd0);
    enc_auto = 1'b1;
    resync();
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecc_op_ctrl.md
Name: ecc_op_ctrl

Overview:
- Operation sequencer for the ECC encoder/decoder datapath.
- Takes the write strobe on the CTRL register plus the latched register-bank outputs (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE).
- Runs one encode, decode or full-channel operation (encode, add noise, decode) through the encoder and decoder using a start/done handshake.
- Returns the result, error count and status to the register bank / APB read path.

Parameters:
- AMBA_WORD, 32, width of data, register and codeword buses.
- TIMEOUT_CYC, 64, watchdog limit in cycles per datapath phase; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse on CTRL register write.
- ctrl  in  AMBA_WORD  operation select; only [1:0] is used. 00 encode, 01 decode, 10 full channel, 11 illegal.
- data_in  in  AMBA_WORD  operand word.
- codeword_width  in  AMBA_WORD  only [1:0] is used. 00=8, 01=16, 10=32, 11 illegal.
- noise  in  AMBA_WORD  noise pattern for full-channel operations.
- enc_start  out  1  one-cycle request to the encoder.
- enc_din  out  AMBA_WORD  encoder operand.
- enc_done  in  1  one-cycle encoder completion pulse.
- enc_dout  in  AMBA_WORD  encoded word; valid when enc_done is high.
- dec_start  out  1  one-cycle request to the decoder.
- dec_din  out  AMBA_WORD  decoder operand.
- dec_done  in  1  one-cycle decoder completion pulse.
- dec_dout  in  AMBA_WORD  decoded word.
- dec_err  in  2  decoder error count: 0, 1, or 2 (uncorrectable).
- busy  out  1  high from start acceptance until return to IDLE.
- data_out  out  AMBA_WORD  result word; held until the next result.
- data_out_valid  out  1  one-cycle pulse when a result is written.
- num_of_errors  out  2  error count of the last operation; 0 for encode.
- op_err  out  1  sticky flag for an illegal operation or width.

Behaviour:
- States: IDLE, ENC, DEC, DONE, ERR.
- Reset: state IDLE; all outputs 0, including data_out and num_of_errors.
- Reset asserted mid-operation aborts immediately. Any later enc_done/dec_done pulse is ignored in IDLE.
- IDLE, start=1:
  - Latch op, width, data_in, and noise & mask, where mask = 0xFF, 0xFFFF or 0xFFFFFFFF by width.
  - Clear op_err.
  - Set busy next cycle.
  - Next state: op 11 or width 11 -> ERR; op 00 or 10 -> ENC; op 01 -> DEC.
- start while busy is ignored. The latched operands and the sequence are unaffected.
- ENC:
  - enc_start pulses in the first cycle of ENC.
  - enc_din = data_in & mask.
  - Wait for enc_done.
  - enc_done with op 00: data_out <= enc_dout & mask, num_of_errors <= 0, go to DONE.
  - enc_done with op 10: dec_din <= enc_dout ^ latched masked noise, go to DEC.
- DEC:
  - dec_start pulses in the first cycle of DEC.
  - For op 01, dec_din = data_in & mask.
  - On dec_done: data_out <= dec_dout & mask, num_of_errors <= dec_err, go to DONE.
- DONE: data_out_valid=1 for one cycle, busy deasserts, go to IDLE.
- ERR: op_err <= 1, data_out unchanged, no enc_start or dec_start, go to IDLE after one cycle.
- A done pulse in the same cycle as the start pulse (state ENC/DEC entry) is ignored. Done is honoured only after the corresponding start pulse.
- Latency with a 1-cycle datapath:
  - Encode: start at cycle 0, enc_start at 1, enc_done at 2, data_out_valid at 3.
  - Full channel: data_out_valid at cycle 5.
- A start pulse in the DONE cycle is ignored. A start pulse in the IDLE cycle that follows is accepted.

Optional Feature:
- Macro: ECC_OP_CTRL_TIMEOUT_EN.
- Defined:
  - A per-phase counter clears on entry to ENC or DEC and increments every cycle in those states.
  - If it reaches TIMEOUT_CYC-1 without the done pulse, go to ERR: op_err=1, num_of_errors=2'b11, no data_out_valid.
- Undefined: no counter; ENC and DEC wait indefinitely.

Decomposition:
- Package ecc_ctrl_pkg holds:
  - Op codes: OP_ENC, OP_DEC, OP_FULL.
  - Width codes: W8, W16, W32.
  - State encoding.
  - width_mask function.
- Sub-module ecc_op_watchdog: counter with clear/enable/expired, instantiated only under the macro.

Test Plan:
1. Encode: ctrl=0, width=0, data_in=0x1A5 -> enc_start at cycle 1, enc_din=0xA5. Encoder returns 0x1234 -> data_out=0x34, num_of_errors=0, one data_out_valid pulse.
2. Full channel: ctrl=2, width=1, noise=0x10004, enc_dout=0xBEEF -> dec_din=0xBEEB. dec_err=1, dec_dout=0x00C3 -> data_out=0xC3, num_of_errors=1, valid at cycle 5.
3. Illegal op/width:
   - ctrl=3 -> op_err=1, no enc_start/dec_start, busy high for 1 cycle.
   - A following legal start clears op_err.
   - Also check width=3 with ctrl=0 -> op_err=1.
4. Start pulses at cycles 1, 2 and 3 of a decode -> exactly one dec_start and one valid pulse. Latched data_in unchanged.
5. rst low mid-DEC -> busy=0, data_out=0. A late dec_done produces no valid pulse.
6. With ECC_OP_CTRL_TIMEOUT_EN, TIMEOUT_CYC=8, encoder never done -> op_err=1 and num_of_errors=3 on cycle 9 after start.
